// File: rtl/bin_to_sseg_digits_if.sv
// Request/result bundle between a producer of binary counts and the
// 7-segment digit converter; master drives value/load, slave returns digits.
interface bin_to_sseg_digits_if #(
  parameter int BIN_W = 27
);
  logic [BIN_W-1:0] value;
  logic             load;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [0:6]       digit0;
  logic [0:6]       digit1;
  logic [0:6]       digit2;
  logic [0:6]       digit3;
  logic [0:6]       digit4;
  logic [0:6]       digit5;
  logic [0:6]       digit6;
  logic [0:6]       digit7;

  // load is a request, taken only while busy=0 and no conversion is pending
  // in the update slot; a load seen at any other time is dropped, never queued.
  modport master (
    output value, load,
    input  busy, done, ovf,
    input  digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7
  );

  modport slave (
    input  value, load,
    output busy, done, ovf,
    output digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7
  );
endinterface

// File: rtl/bin_to_sseg_digits.sv
// Binary -> eight active-low 7-segment patterns via iterative double-dabble.
// Define LEADING_ZERO_BLANK_EN to blank zeros above the most-significant digit.
module bin_to_sseg_digits #(
  parameter int BIN_W = 27
) (
  input  logic                   ck,
  input  logic                   rst,
  bin_to_sseg_digits_if.slave    bus,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [0:6]  SEG_BLANK = 7'b1111111;
  localparam logic [0:6]  SEG_DASH  = 7'b1111110;
  localparam logic [31:0] MAX_SHOW  = 32'd99_999_999;

  state_t           state;
  logic [BIN_W-1:0] bin_q;
  logic [31:0]      bcd_q;
  logic [4:0]       iter_q;
  logic             ovf_next;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;
  logic [0:6]       seg_q   [8];
  logic [0:6]       seg_nxt [8];

  logic [31:0]        bcd_adj;
  logic [31+BIN_W:0]  shifted;
  logic [31:0]        value_ext;

  function automatic logic [0:6] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b0000001;
      4'd1:    seg_of = 7'b1001111;
      4'd2:    seg_of = 7'b0010010;
      4'd3:    seg_of = 7'b0000110;
      4'd4:    seg_of = 7'b1001100;
      4'd5:    seg_of = 7'b0100100;
      4'd6:    seg_of = 7'b0100000;
      4'd7:    seg_of = 7'b0001111;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0000100;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  assign value_ext = {{(32-BIN_W){1'b0}}, bus.value};

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin}.
  // Bits leaving bcd[31] only occur on overflow, which is shown as dashes.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    logic seen;
    seen = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      seg_nxt[i] = seg_of(bcd_q[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (bcd_q[4*i +: 4] != 4'd0 || i == 0) seen = 1'b1;
      if (!seen) seg_nxt[i] = SEG_BLANK;
`endif
      if (ovf_next) seg_nxt[i] = SEG_DASH;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state    <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      ovf_next <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < 8; i++) seg_q[i] <= SEG_BLANK;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            bin_q    <= bus.value;
            bcd_q    <= '0;
            iter_q   <= '0;
            ovf_next <= (value_ext > MAX_SHOW);
            busy_q   <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          bcd_q  <= shifted[31+BIN_W:BIN_W];
          bin_q  <= shifted[BIN_W-1:0];
          iter_q <= iter_q + 5'd1;
          if (iter_q == 5'(BIN_W-1)) begin
            busy_q <= 1'b0;
            state  <= UPDATE;
          end
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) seg_q[i] <= seg_nxt[i];
          ovf_q  <= ovf_next;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ovf    = ovf_q;
  assign bus.digit0 = seg_q[0];
  assign bus.digit1 = seg_q[1];
  assign bus.digit2 = seg_q[2];
  assign bus.digit3 = seg_q[3];
  assign bus.digit4 = seg_q[4];
  assign bus.digit5 = seg_q[5];
  assign bus.digit6 = seg_q[6];
  assign bus.digit7 = seg_q[7];
  assign state_dbg  = state;

endmodule
